// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the core control path and the mul/div sequencer.
// Holds operation requests, HI/LO reads, status outputs and a debug view of the FSM state.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    // Handshake: a request (op_valid or mf_req) is consumed on a rising edge only when
    // busy is low; while busy it raises stall and the core must hold it unchanged.
    logic             op_valid;
    logic [2:0]       op_code;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             mf_req;
    logic             mf_sel;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             done;
    logic             div_zero;
    logic [1:0]       dbg_state;

    modport master (
        output op_valid, op_code, op_a, op_b, flush, mf_req, mf_sel,
        input  mf_data, hi, lo, busy, stall, done, div_zero, dbg_state
    );

    modport slave (
        input  op_valid, op_code, op_a, op_b, flush, mf_req, mf_sel,
        output mf_data, hi, lo, busy, stall, done, div_zero, dbg_state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One shift-add or restoring-divide step per clock on operand magnitudes, signs fixed up at the end.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q,      state_d;
    logic [CW-1:0]      cnt_q,        cnt_d;
    logic [WIDTH-1:0]   hi_q,         hi_d;
    logic [WIDTH-1:0]   lo_q,         lo_d;
    logic [2*WIDTH-1:0] prod_q,       prod_d;
    logic [WIDTH-1:0]   mcand_q,      mcand_d;
    logic [WIDTH-1:0]   rem_q,        rem_d;
    logic [WIDTH-1:0]   quo_q,        quo_d;
    logic [WIDTH-1:0]   raw_a_q,      raw_a_d;
    logic               is_div_q,     is_div_d;
    logic               div0_q,       div0_d;
    logic               sign_quo_q,   sign_quo_d;
    logic               sign_rem_q,   sign_rem_d;
    logic               done_q,       done_d;
    logic               div_zero_q,   div_zero_d;

    logic               busy;
    logic               req_ok;
    logic               is_muldiv;
    logic               is_div_op;
    logic               signed_op;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   mul_addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign busy      = (state_q != S_IDLE);
    assign req_ok    = bus.op_valid & ~busy & ~bus.flush;
    assign is_muldiv = ~bus.op_code[2];
    assign is_div_op = bus.op_code[1];
    assign signed_op = ~bus.op_code[0];
    assign sa        = signed_op & bus.op_a[WIDTH-1];
    assign sb        = signed_op & bus.op_b[WIDTH-1];
    assign mag_a     = sa ? -bus.op_a : bus.op_a;
    assign mag_b     = sb ? -bus.op_b : bus.op_b;

    // Multiply: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    assign mul_addend = prod_q[0] ? mcand_q : '0;
    assign mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // Divide: a clear borrow bit means the shifted partial remainder covers the divisor.
    assign div_shift  = {rem_q, quo_q[WIDTH-1]};
    assign div_diff   = div_shift - {1'b0, mcand_q};
    assign div_fits   = ~div_diff[WIDTH];

    assign prod_fix = sign_quo_q ? -prod_q : prod_q;
    assign quo_fix  = sign_quo_q ? -quo_q  : quo_q;
    assign rem_fix  = sign_rem_q ? -rem_q  : rem_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        prod_d     = prod_q;
        mcand_d    = mcand_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        raw_a_d    = raw_a_q;
        is_div_d   = is_div_q;
        div0_d     = div0_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        done_d     = 1'b0;
        div_zero_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    if (is_muldiv) begin
                        state_d    = S_CALC;
                        cnt_d      = CNT_INIT;
                        mcand_d    = is_div_op ? mag_b : mag_a;
                        prod_d     = {{WIDTH{1'b0}}, mag_b};
                        quo_d      = mag_a;
                        rem_d      = '0;
                        raw_a_d    = bus.op_a;
                        is_div_d   = is_div_op;
                        div0_d     = is_div_op & (bus.op_b == '0);
                        sign_quo_d = sa ^ sb;
                        sign_rem_d = sa;
                    end else if (bus.op_code == OP_MTHI) begin
                        hi_d = bus.op_a;
                    end else if (bus.op_code == OP_MTLO) begin
                        lo_d = bus.op_a;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (is_div_q) begin
                        rem_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], div_fits};
                    end else begin
                        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                    end
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                // A flush on this edge cancels the write-back as well.
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (div0_q) begin
                        hi_d       = raw_a_q;
                        lo_d       = '1;
                        div_zero_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            prod_q     <= '0;
            mcand_q    <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            raw_a_q    <= '0;
            is_div_q   <= 1'b0;
            div0_q     <= 1'b0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            prod_q     <= prod_d;
            mcand_q    <= mcand_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            raw_a_q    <= raw_a_d;
            is_div_q   <= is_div_d;
            div0_q     <= div0_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.mf_data   = bus.mf_sel ? hi_q : lo_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.busy      = busy;
    assign bus.stall     = busy & (bus.op_valid | bus.mf_req);
    assign bus.done      = done_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: driver tasks push expected HI/LO/div_zero into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    muldiv_sequencer_if #(.WIDTH(W)) bus ();

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int errors    = 0;
    int done_seen = 0;
    int pushed    = 0;
    logic [2*W:0] exp_q[$];
    logic [2*W:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hilo", {bus.hi, bus.lo}, mon_exp[2*W-1:0]);
                check("div_zero", {63'd0, bus.div_zero}, {63'd0, mon_exp[2*W]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_a     = a;
        bus.op_b     = b;
        step();
        bus.op_valid = 1'b0;
    endtask

    task automatic expect_result(input logic dz, input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_q.push_back({dz, hi, lo});
        pushed++;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            step();
        end
        if (cyc >= 100) check("busy_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int stall_bad;
        bus.op_valid = 1'b0;
        bus.op_code  = 3'd0;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;
        bus.mf_req   = 1'b0;
        bus.mf_sel   = 1'b0;

        repeat (2) step();
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_div_zero", bus.div_zero, 0);
        check("rst_state", bus.dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // MULT -3 * 7
        expect_result(1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        start_op(3'd0, 32'hFFFFFFFD, 32'd7);
        wait_idle(cyc);
        check("mult_busy_cycles", cyc, 33);

        // DIVU 100 / 7, DIV -7 / 2, DIV 7 / -2
        expect_result(1'b0, 32'h00000002, 32'h0000000E);
        start_op(3'd3, 32'd100, 32'd7);
        wait_idle(cyc);
        expect_result(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        start_op(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(cyc);
        expect_result(1'b0, 32'h00000001, 32'hFFFFFFFD);
        start_op(3'd2, 32'd7, 32'hFFFFFFFE);
        wait_idle(cyc);

        // Divide by zero still takes the full latency; next op proceeds normally
        expect_result(1'b1, 32'h00000005, 32'hFFFFFFFF);
        start_op(3'd2, 32'd5, 32'd0);
        wait_idle(cyc);
        check("div0_busy_cycles", cyc, 33);
        expect_result(1'b0, 32'h00000000, 32'h0000002A);
        start_op(3'd1, 32'd6, 32'd7);
        wait_idle(cyc);

        // Signed overflow 0x80000000 / -1
        expect_result(1'b0, 32'h00000000, 32'h80000000);
        start_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(cyc);

        // MULTU max * max with mf_req held from the second busy cycle
        expect_result(1'b0, 32'hFFFFFFFE, 32'h00000001);
        start_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        step();
        bus.mf_req = 1'b1;
        bus.mf_sel = 1'b1;
        #1;
        stall_bad = 0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            if (bus.stall !== 1'b1) stall_bad++;
            cyc++;
            step();
        end
        check("stall_while_busy", stall_bad, 0);
        check("stall_cycles", cyc, 32);
        check("stall_idle", bus.stall, 0);
        check("mf_data_hi", bus.mf_data, 32'hFFFFFFFE);
        check("lo_after_multu", bus.lo, 32'h00000001);
        bus.mf_sel = 1'b0;
        #1;
        check("mf_data_lo", bus.mf_data, 32'h00000001);
        bus.mf_req = 1'b0;

        // MTLO when idle: zero latency
        start_op(3'd5, 32'h00001234, 32'd0);
        check("mtlo_lo", bus.lo, 32'h00001234);
        check("mtlo_busy", bus.busy, 0);
        check("mtlo_hi_kept", bus.hi, 32'hFFFFFFFE);

        // MTHI while busy: stalls and never writes
        expect_result(1'b0, 32'hFFFFFFFF, 32'hFFFF0000);
        start_op(3'd0, 32'h00010000, 32'hFFFFFFFF);
        bus.op_valid = 1'b1;
        bus.op_code  = 3'd4;
        bus.op_a     = 32'hDEADBEEF;
        #1;
        check("mthi_stall", bus.stall, 1);
        repeat (3) step();
        check("mthi_busy_hi", bus.hi, 32'hFFFFFFFE);
        bus.op_valid = 1'b0;
        wait_idle(cyc);

        // flush at CALC cycle 10: no done, HI/LO keep prior values
        start_op(3'd3, 32'd1000, 32'd3);
        repeat (9) step();
        check("pre_flush_state", bus.dbg_state, 1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", bus.busy, 0);
        check("flush_hi", bus.hi, 32'hFFFFFFFF);
        check("flush_lo", bus.lo, 32'hFFFF0000);
        repeat (40) step();

        // flush while idle drops a coincident op; op_code 6 is a no-op
        bus.flush = 1'b1;
        start_op(3'd0, 32'd2, 32'd2);
        bus.flush = 1'b0;
        check("idle_flush_busy", bus.busy, 0);
        start_op(3'd6, 32'h55555555, 32'h1);
        check("nop_busy", bus.busy, 0);
        check("nop_lo", bus.lo, 32'hFFFF0000);

        // Asynchronous reset mid-operation
        start_op(3'd0, 32'd3, 32'd3);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        expect_result(1'b0, 32'h00000000, 32'h0000002A);
        start_op(3'd1, 32'd6, 32'd7);
        wait_idle(cyc);
        check("post_rst_busy_cycles", cyc, 33);

        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);
        check("done_count", done_seen, pushed);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
